// File: rtl/dcache_port_arbiter.sv
// Shares one pulse-handshake dcache port between two requesters (r0 = Mem stage, r1 = fetch/walk).
// Define DCACHE_ARB_RR_EN for round-robin arbitration; otherwise r0 has fixed priority.
module dcache_port_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_r0_en,
    input  logic              i_r0_wren,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic [DATA_W-1:0] o_r0_rdata,
    output logic              o_r0_done,
    input  logic              i_r1_en,
    input  logic              i_r1_wren,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_r1_done,
    output logic              o_dcache_en,
    output logic              o_dcache_wren,
    output logic [ADDR_W-1:0] o_dcache_addr,
    output logic [DATA_W-1:0] o_dcache_wdata,
    input  logic [DATA_W-1:0] i_dcache_rdata,
    input  logic              i_dcache_done,
    output logic              o_busy,
    output logic              o_owner,
    output logic              o_proto_err
);

    typedef enum logic {StIdle, StWait} state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [1:0]        r_pend;
    logic [1:0]        r_pwren;
    logic [ADDR_W-1:0] r_paddr [2];
    logic [DATA_W-1:0] r_pwdata [2];
    logic              r_last_grant;
    logic              r_owner;
    logic              r_dc_en;
    logic              r_dc_wren;
    logic [ADDR_W-1:0] r_dc_addr;
    logic [DATA_W-1:0] r_dc_wdata;
    logic [1:0]        r_done;
    logic [DATA_W-1:0] r_rdata [2];
    logic              r_proto_err;

    logic [1:0]        w_en;
    logic [1:0]        w_wren;
    logic [ADDR_W-1:0] w_addr [2];
    logic [DATA_W-1:0] w_wdata [2];
    logic [1:0]        w_viol;
    logic [1:0]        w_accept;
    logic [1:0]        w_cand;
    logic              w_in_wait;
    logic              w_grant;
    logic              w_complete;
    logic              w_winner;
    logic              w_sel_wren;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_en       = {i_r1_en, i_r0_en};
    assign w_wren     = {i_r1_wren, i_r0_wren};
    assign w_addr[0]  = i_r0_addr;
    assign w_addr[1]  = i_r1_addr;
    assign w_wdata[0] = i_r0_wdata;
    assign w_wdata[1] = i_r1_wdata;
    assign w_in_wait  = (r_state == StWait);

    // The owner may legally re-strobe in the very cycle its completion arrives.
    assign w_viol[0] = w_en[0] & (r_pend[0] | (w_in_wait & ~r_owner & ~i_dcache_done));
    assign w_viol[1] = w_en[1] & (r_pend[1] | (w_in_wait & r_owner & ~i_dcache_done));
    assign w_accept  = w_en & ~w_viol;
    assign w_cand    = r_pend | w_accept;

`ifdef DCACHE_ARB_RR_EN
    assign w_winner = (&w_cand) ? ~r_last_grant : w_cand[1];
`else
    logic unused_last_grant;
    assign unused_last_grant = r_last_grant;
    assign w_winner          = ~w_cand[0];
`endif

    // A fresh strobe bypasses its (empty) slot so grant latency is one cycle.
    assign w_sel_wren  = r_pend[w_winner] ? r_pwren[w_winner]  : w_wren[w_winner];
    assign w_sel_addr  = r_pend[w_winner] ? r_paddr[w_winner]  : w_addr[w_winner];
    assign w_sel_wdata = r_pend[w_winner] ? r_pwdata[w_winner] : w_wdata[w_winner];

    always_comb begin
        w_state_d  = r_state;
        w_grant    = 1'b0;
        w_complete = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (|w_cand) begin
                    w_grant   = 1'b1;
                    w_state_d = StWait;
                end
            end
            StWait: begin
                if (i_dcache_done) begin
                    w_complete = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_pend       <= '0;
            r_pwren      <= '0;
            r_paddr      <= '{default: '0};
            r_pwdata     <= '{default: '0};
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_dc_en      <= 1'b0;
            r_dc_wren    <= 1'b0;
            r_dc_addr    <= '0;
            r_dc_wdata   <= '0;
            r_done       <= '0;
            r_rdata      <= '{default: '0};
            r_proto_err  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_dc_en <= w_grant;
            r_done  <= '0;
            if (|w_viol) begin
                r_proto_err <= 1'b1;
            end
            if (w_accept[0]) begin
                r_pend[0]   <= 1'b1;
                r_pwren[0]  <= w_wren[0];
                r_paddr[0]  <= w_addr[0];
                r_pwdata[0] <= w_wdata[0];
            end
            if (w_accept[1]) begin
                r_pend[1]   <= 1'b1;
                r_pwren[1]  <= w_wren[1];
                r_paddr[1]  <= w_addr[1];
                r_pwdata[1] <= w_wdata[1];
            end
            // Placed after the slot capture so a granted bypass strobe leaves no slot behind.
            if (w_grant) begin
                r_pend[w_winner] <= 1'b0;
                r_owner          <= w_winner;
                r_dc_wren        <= w_sel_wren;
                r_dc_addr        <= w_sel_addr;
                r_dc_wdata       <= w_sel_wdata;
            end
            if (w_complete) begin
                r_done[r_owner]  <= 1'b1;
                r_rdata[r_owner] <= i_dcache_rdata;
                r_last_grant     <= r_owner;
            end
        end
    end

    assign o_r0_rdata     = r_rdata[0];
    assign o_r0_done      = r_done[0];
    assign o_r1_rdata     = r_rdata[1];
    assign o_r1_done      = r_done[1];
    assign o_dcache_en    = r_dc_en;
    assign o_dcache_wren  = r_dc_wren;
    assign o_dcache_addr  = r_dc_addr;
    assign o_dcache_wdata = r_dc_wdata;
    assign o_busy         = w_in_wait;
    assign o_owner        = r_owner;
    assign o_proto_err    = r_proto_err;

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single dcache request port between two requesters: the Mem stage (r0) and the fetch/page-walk unit (r1).
- Each requester uses the same pulse-style en/wren/addr/wdata -> rdata/done handshake the dcache itself uses, so either side connects unchanged.
- Captures requests, serialises them onto the dcache one at a time, and routes each completion back to its owner.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
r0_en  in  1  requester 0 request strobe (one-cycle pulse)
r0_wren  in  1  requester 0 write (1) / read (0), sampled with r0_en
r0_addr  in  ADDR_W  requester 0 address, sampled with r0_en
r0_wdata  in  DATA_W  requester 0 write data, sampled with r0_en
r0_rdata  out  DATA_W  requester 0 read data, valid while r0_done=1
r0_done  out  1  requester 0 completion pulse
r1_en, r1_wren, r1_addr, r1_wdata, r1_rdata, r1_done  (same widths and meanings as r0_*, for requester 1)
dcache_en  out  1  downstream request pulse
dcache_wren  out  1  downstream write flag
dcache_addr  out  ADDR_W  downstream address
dcache_wdata  out  DATA_W  downstream write data
dcache_rdata  in  DATA_W  downstream read data
dcache_done  in  1  downstream completion
busy  out  1  a transaction is in flight (state WAIT)
owner  out  1  requester index of the in-flight transaction
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high.
- Reset values: all outputs 0; pend0 = pend1 = 0; state IDLE; last_grant = 1, so r0 wins the first contention.
- Per-requester pending slot:
  - On rN_en at a clk edge, {wren, addr, wdata} are latched and pendN is set.
  - pendN clears at the edge where requester N is granted.
- States are IDLE and WAIT.
- IDLE:
  - Candidates are pendN OR rN_en in the current cycle. An incoming strobe bypasses the slot, so grant latency is 1 cycle.
  - If any candidate exists at edge k: select the winner and drive its fields onto dcache_wren/addr/wdata (registered, held until the next grant).
  - dcache_en=1 for exactly the cycle after edge k. owner=winner, busy=1, go to WAIT.
  - A losing strobe that arrives in the same cycle is latched into its pending slot.
- WAIT:
  - dcache_en=0.
  - On dcache_done at edge j: r{owner}_done=1 and r{owner}_rdata=dcache_rdata for the one cycle after j. The other requester's done stays 0.
  - At edge j: busy=0, last_grant=owner, return to IDLE.
  - The next grant can occur at edge j+1, so back-to-back transactions have one idle cycle between them.
- rdata on writes: on a write completion rdata carries dcache_rdata unchanged. Requesters ignore it.
- Arbitration without the optional feature: fixed priority, r0 over r1.
- Protocol violation:
  - Trigger: rN_en while requester N already has pendN=1, or while requester N owns the in-flight transaction.
  - Response: the strobe is dropped, existing state is unaffected, and proto_err is set (sticky until reset).
- dcache_done in IDLE, including one arriving after a mid-transaction reset, is ignored. No rN_done is produced.
- Reset during WAIT aborts the transaction. Both pending slots clear and no done is delivered. Requesters are reset alongside.
- Simultaneous rN_en and dcache_done for requester N's previous request: legal. Completion is delivered and the new request is captured into pendN.

Optional Feature:
- Macro: DCACHE_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are candidates in IDLE, grant the one != last_grant. A single candidate always wins.
- Undefined: fixed priority, r0 always beats r1. last_grant is still maintained but is unused.

Test Plan:
- r0 read, addr 0x1000, no contention: dcache_en pulses 1 cycle after r0_en, dcache_addr=0x1000, dcache_wren=0. Dcache returns 0xDEADBEEF with done 3 cycles later -> r0_done pulses once with r0_rdata=0xDEADBEEF; r1_done stays 0; busy falls.
- r0 write (0x2000, 0x55) and r1 read (0x3000) strobed in the same cycle: r0 is granted first and r1 is pended. After r0 completes plus 1 idle cycle, dcache_addr=0x3000 issues; r1_done follows its done.
- Same-cycle strobes repeated on three transactions with DCACHE_ARB_RR_EN defined: grant order r0, r1, r0. Without the macro: r0 always first when both are pending.
- r1 strobes again while its own request is in WAIT: proto_err=1 and stays high; no extra dcache_en; the original r1 completion is delivered normally.
- reset asserted mid-WAIT, then dcache_done arrives after release: all outputs 0, no rN_done pulse, state IDLE; a following r0 read issues normally.
- r0_en coincident with dcache_done for r0's prior read: r0_done pulses and the new request issues at edge j+1 with its addr.
